// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel gradient-magnitude filter with valid/ready handshakes.
// Optional build macro SOBEL_THRESHOLD_EN adds a threshold port that binarises
// the magnitude (all-ones at or above threshold, zero below).
module sobel_stream_filter #(
  parameter int PIX_W   = 8,
  parameter int COL_NUM = 640,
  parameter int ROW_NUM = 480,
  parameter int OUT_W   = PIX_W + 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_pixel,
  output logic             out_sof,
  output logic             out_eol,
  output logic             frame_done,
`ifdef SOBEL_THRESHOLD_EN
  input  logic [OUT_W-1:0] threshold,
`endif
  output logic             busy
);

  localparam int XW = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
  localparam int YW = $clog2(ROW_NUM + 2);
  localparam int GW = PIX_W + 4;

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t state, state_next;

  // The input counters keep running through FLUSH as a pseudo position for the
  // injected zero pixels; the centre counters alone decide edge masking.
  logic [XW-1:0] in_x, cen_x;
  logic [YW-1:0] in_y, cen_y;
  logic          all_done;

  logic [PIX_W-1:0] lb_old [COL_NUM];
  logic [PIX_W-1:0] lb_new [COL_NUM];
  logic [PIX_W-1:0] tl, ml, bl, tc, mc, bc;
  logic [PIX_W-1:0] col_top, col_mid, col_bot;

  logic in_fire, flush_slot, compute, shift, last_xfer;
  logic top_ok, bot_ok, left_ok, right_ok;
  logic signed [GW-1:0] n_tl, n_tc, n_tr, n_ml, n_mr, n_bl, n_bc, n_br;
  logic signed [GW-1:0] gx, gy, ax, ay;
  logic [OUT_W-1:0] mag, result;

  assign in_ready   = !rst && ((state == FILL) ||
                               (state == RUN && (out_ready || !out_valid)));
  assign busy       = !rst && (state != IDLE);
  assign in_fire    = in_valid && in_ready;
  assign flush_slot = (state == FLUSH) && !all_done && (out_ready || !out_valid);
  assign compute    = ((state == RUN) && in_fire) || flush_slot;
  assign shift      = in_fire || flush_slot;
  assign last_xfer  = (state == FLUSH) && all_done && out_valid && out_ready;

  // The newest window column: two rows from the line buffers plus the incoming (or zero) pixel.
  assign col_top = lb_old[in_x];
  assign col_mid = lb_new[in_x];
  assign col_bot = (state == FLUSH) ? '0 : in_pixel;

  assign top_ok   = (cen_y != '0);
  assign bot_ok   = (cen_y != YW'(ROW_NUM - 1));
  assign left_ok  = (cen_x != '0);
  assign right_ok = (cen_x != XW'(COL_NUM - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: arm on en, prime C+1 pixels, stream, then drain the lagging outputs.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (en) state_next = FILL;
      FILL:  if (in_fire && in_x == '0 && in_y == YW'(1)) state_next = RUN;
      RUN:   if (in_fire && in_x == XW'(COL_NUM - 1) && in_y == YW'(ROW_NUM - 1))
               state_next = FLUSH;
      FLUSH: if (last_xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Position counters; holding them at zero in IDLE makes every frame start at (0,0).
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      in_x     <= '0;
      in_y     <= '0;
      cen_x    <= '0;
      cen_y    <= '0;
      all_done <= 1'b0;
    end else begin
      if (shift) begin
        if (in_x == XW'(COL_NUM - 1)) begin
          in_x <= '0;
          in_y <= in_y + 1'b1;
        end else begin
          in_x <= in_x + 1'b1;
        end
      end
      if (compute) begin
        if (cen_x == XW'(COL_NUM - 1)) begin
          cen_x <= '0;
          cen_y <= cen_y + 1'b1;
          if (cen_y == YW'(ROW_NUM - 1)) all_done <= 1'b1;
        end else begin
          cen_x <= cen_x + 1'b1;
        end
      end
    end
  end

  // Line buffers and the two retained window columns; stale data is masked, so no reset.
  always_ff @(posedge clk) begin
    if (shift) begin
      lb_old[in_x] <= col_mid;
      lb_new[in_x] <= col_bot;
      tl <= tc;
      ml <= mc;
      bl <= bc;
      tc <= col_top;
      mc <= col_mid;
      bc <= col_bot;
    end
  end

  // Mask out-of-frame neighbours to zero and form the gradient magnitude.
  always_comb begin
    n_tl = (top_ok && left_ok)  ? GW'(tl)      : '0;
    n_tc = top_ok               ? GW'(tc)      : '0;
    n_tr = (top_ok && right_ok) ? GW'(col_top) : '0;
    n_ml = left_ok              ? GW'(ml)      : '0;
    n_mr = right_ok             ? GW'(col_mid) : '0;
    n_bl = (bot_ok && left_ok)  ? GW'(bl)      : '0;
    n_bc = bot_ok               ? GW'(bc)      : '0;
    n_br = (bot_ok && right_ok) ? GW'(col_bot) : '0;
    gx = (n_tr + (n_mr <<< 1) + n_br) - (n_tl + (n_ml <<< 1) + n_bl);
    gy = (n_bl + (n_bc <<< 1) + n_br) - (n_tl + (n_tc <<< 1) + n_tr);
    ax = gx[GW-1] ? -gx : gx;
    ay = gy[GW-1] ? -gy : gy;
    mag = OUT_W'(ax) + OUT_W'(ay);
`ifdef SOBEL_THRESHOLD_EN
    result = (mag >= threshold) ? '1 : '0;
`else
    result = mag;
`endif
  end

  // Output register: load on compute, otherwise drop valid once consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else if (compute) begin
      out_valid <= 1'b1;
      out_pixel <= result;
      out_sof   <= (cen_x == '0) && (cen_y == '0);
      out_eol   <= (cen_x == XW'(COL_NUM - 1));
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // One-cycle pulse following the final output transfer of the frame.
  always_ff @(posedge clk) begin
    if (rst) frame_done <= 1'b0;
    else     frame_done <= last_xfer;
  end

endmodule

// File: doc/sobel_stream_filter.md
SOBEL_STREAM_FILTER -- requirements
Module: sobel_stream_filter

Interface
REQ-001 Parameters (name, default, meaning): PIX_W, 8, input pixel width; COL_NUM, 640, pixels per row (>=3); ROW_NUM, 480, rows per frame (>=3); OUT_W, PIX_W+3, magnitude width.
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 en  in  1  arms the block for one frame while IDLE.
REQ-005 in_valid / in_ready  in / out  1 / 1  input stream handshake; pixels arrive in raster order.
REQ-006 in_pixel  in  PIX_W  unsigned input pixel.
REQ-007 out_valid / out_ready  out / in  1 / 1  output stream handshake.
REQ-008 out_pixel  out  OUT_W  gradient magnitude, raster order.
REQ-009 out_sof / out_eol  out  1 / 1  first pixel of frame / last pixel of row, qualified by out_valid.
REQ-010 frame_done  out  1  one-cycle pulse after the last output transfer of a frame.
REQ-011 busy  out  1  high in any state other than IDLE.

Function
REQ-012 Transfers occur only when valid and ready are both high on a rising edge; out_valid/out_pixel/flags hold stable while out_valid=1 and out_ready=0.
REQ-013 FSM states: IDLE, FILL, RUN, FLUSH; IDLE->FILL on en=1; FILL->RUN after COL_NUM+1 input accepts; RUN->FLUSH on acceptance of input pixel (COL_NUM-1,ROW_NUM-1); FLUSH->IDLE after output (COL_NUM-1,ROW_NUM-1) transfers.
REQ-014 in_ready = 0 in IDLE and FLUSH; in FILL = 1; in RUN = out_ready OR NOT out_valid.
REQ-015 Two line buffers of COL_NUM x PIX_W plus a 3x3 window register; window centre lags the input position by COL_NUM+1 pixels.
REQ-016 Each input accept in RUN, and each output slot in FLUSH (zero pixel injected), computes exactly one output at centre (x,y); result is registered, so out_valid rises the cycle after the triggering accept.
REQ-017 Exactly ROW_NUM*COL_NUM outputs per frame; no output in FILL.
REQ-018 Neighbours outside the frame (x<0, x>=COL_NUM, y<0, y>=ROW_NUM) read as 0; no wrap-around between rows or frames.
REQ-019 Gx = (TR+2*MR+BR) - (TL+2*ML+BL); Gy = (BL+2*BC+BR) - (TL+2*TC+TR); signed arithmetic at PIX_W+4 bits, no overflow.
REQ-020 out_pixel = |Gx|+|Gy|, exact in OUT_W bits (max 8*(2^PIX_W-1)).
REQ-021 out_sof = 1 only for centre (0,0); out_eol = 1 for centre x=COL_NUM-1.
REQ-022 frame_done pulses the cycle after the final output transfer; FSM is in IDLE that same cycle; en sampled only in IDLE.
REQ-023 en=1 while busy is ignored.

Reset
REQ-024 rst=1 forces: state IDLE, position counters 0, out_valid=0, out_pixel=0, out_sof=0, out_eol=0, frame_done=0, busy=0, in_ready=0.
REQ-025 rst mid-frame abandons the frame; line-buffer contents are don't-care because REQ-018 masking uses counters only; next frame starts at (0,0).
REQ-026 rst has priority over every handshake on the same edge.

Configuration
REQ-027 Macro SOBEL_THRESHOLD_EN: when defined, port threshold (in, OUT_W) is added and out_pixel = all-ones if magnitude >= threshold, else 0; when undefined, the port is absent and out_pixel is the raw magnitude per REQ-020.

Verification (COL_NUM=8, ROW_NUM=4, PIX_W=8, macro off unless stated)
REQ-028 Constant frame of 100, out_ready=1 -> (0,0)=600, (5,0)=400, (3,2)=0, 32 outputs, out_sof on first only, out_eol on every 8th, frame_done once.
REQ-029 Single 255 at (3,2), all else 0 -> (2,2)=510, (2,1)=510, (3,2)=0, (0,0)=0.
REQ-030 Columns 0-3 =0, columns 4-7 =255 -> (3,1)=1020, (4,1)=1020, (1,1)=0.
REQ-031 out_ready held low 10 cycles mid-RUN -> out_pixel/out_valid unchanged, in_ready=0, no output lost or duplicated across 32 outputs.
REQ-032 rst pulsed after 15 accepts, then en and a fresh frame -> out_valid=0 during rst, second frame output matches REQ-028 exactly.
REQ-033 Macro on, threshold=500, constant 100 frame -> (0,0)=2047, (5,0)=0, (3,2)=0.
